// File: rtl/i2c_bus_conditioner.sv
// I2C pin front end: synchronises SCL/SDA, strobes SCL edges and START/STOP, tracks bus ownership.
// Define I2C_GLITCH_FILTER_EN to build the per-line glitch filter; otherwise lines come straight from the synchroniser.
module i2c_bus_conditioner #(
    parameter int unsigned FILTER_LEN     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_bit,
    output logic start,
    output logic rstart,
    output logic stop,
    output logic bus_busy,
    output logic scl_stuck
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        BUSY  = 2'd1,
        STUCK = 2'd2
    } state_t;

    // Parameter legality, resolved at elaboration
    if (FILTER_LEN == 0 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("FILTER_LEN must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // Two-flop synchronisers, reset high so the bus reads idle
    logic [1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

`ifdef I2C_GLITCH_FILTER_EN
    localparam int unsigned FW = 4;
    logic [FW-1:0] scl_cnt, sda_cnt;

    // A new level must persist FILTER_LEN cycles before the filtered line follows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_s == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FW'(FILTER_LEN - 1)) begin
                scl_f   <= scl_s;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + FW'(1);
            end

            if (sda_s == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FW'(FILTER_LEN - 1)) begin
                sda_f   <= sda_s;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + FW'(1);
            end
        end
    end
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    logic scl_p, sda_p;
    logic rise_c, fall_c, start_c, stop_c;

    assign rise_c  = scl_f & ~scl_p;
    assign fall_c  = ~scl_f & scl_p;
    assign start_c = sda_p & ~sda_f & scl_p & scl_f;
    assign stop_c  = ~sda_p & sda_f & scl_p & scl_f;

    state_t        state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic          rstart_nx;

    // Bus ownership and SCL-low watchdog
    always_comb begin
        state_nx  = state;
        tcnt_nx   = '0;
        rstart_nx = 1'b0;
        unique case (state)
            FREE: begin
                if (start_c) state_nx = BUSY;
            end
            BUSY: begin
                rstart_nx = start_c;
                if (stop_c)                              state_nx = FREE;
                else if (tcnt == TW'(TIMEOUT_CYCLES))    state_nx = STUCK;
            end
            STUCK: begin
                rstart_nx = start_c;
                if (rise_c || start_c) state_nx = BUSY;
                else if (stop_c)       state_nx = FREE;
            end
            default: state_nx = FREE;
        endcase
        if (state == BUSY && state_nx == BUSY && !scl_f)
            tcnt_nx = (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FREE;
            tcnt      <= '0;
            scl_p     <= 1'b1;
            sda_p     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            sda_bit   <= 1'b1;
            start     <= 1'b0;
            rstart    <= 1'b0;
            stop      <= 1'b0;
            bus_busy  <= 1'b0;
            scl_stuck <= 1'b0;
        end else begin
            state     <= state_nx;
            tcnt      <= tcnt_nx;
            scl_p     <= scl_f;
            sda_p     <= sda_f;
            scl_rise  <= rise_c;
            scl_fall  <= fall_c;
            start     <= start_c;
            rstart    <= rstart_nx;
            stop      <= stop_c;
            if (rise_c) sda_bit <= sda_f;
            bus_busy  <= (state_nx != FREE);
            scl_stuck <= (state_nx == STUCK);
        end
    end
endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Bench for i2c_bus_conditioner: directed bus scenarios plus random pin activity,
// every cycle checked against a sample-history model of the conditioner.
`timescale 1ns/1ps
module tb_i2c_bus_conditioner;
    localparam int unsigned FLEN = 3;
    localparam int unsigned TOUT = 50;
`ifdef I2C_GLITCH_FILTER_EN
    localparam int EFL            = int'(FLEN);
    localparam int GLITCH2_STARTS = 0;
`else
    localparam int EFL            = 0;
    localparam int GLITCH2_STARTS = 1;
`endif

    logic clk, reset, scl_in, sda_in;
    logic scl_f, sda_f, scl_rise, scl_fall, sda_bit, start, rstart, stop, bus_busy, scl_stuck;

    i2c_bus_conditioner #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .sda_bit(sda_bit), .start(start), .rstart(rstart), .stop(stop),
        .bus_busy(bus_busy), .scl_stuck(scl_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int c_start = 0, c_rstart = 0, c_stop = 0, c_fall = 0;
    logic bitq[$];

    // Model: pin sample history (bit 0 = newest), filtered lines now and one cycle ago, bus flags
    logic [31:0] h_scl, h_sda;
    logic m_scl, m_sda, p_scl, p_sda, n_scl, n_sda;
    logic e_rise, e_fall, e_bit, e_start, e_rstart, e_stop;
    logic m_busy, m_stuck, nb, ns, was_busy_only;
    int   m_low;

    // The filtered line flips once the last EFL synchronised samples all disagree with it
    function automatic logic filt(input logic [31:0] h, input logic f);
        if (EFL == 0) return h[0];
        for (int i = 1; i <= EFL; i++)
            if (h[i] == f) return f;
        return ~f;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            h_scl = '1; h_sda = '1;
            m_scl = 1'b1; m_sda = 1'b1; p_scl = 1'b1; p_sda = 1'b1;
            e_rise = 1'b0; e_fall = 1'b0; e_bit = 1'b1;
            e_start = 1'b0; e_rstart = 1'b0; e_stop = 1'b0;
            m_busy = 1'b0; m_stuck = 1'b0; m_low = 0;
        end else begin
            e_rise   = m_scl & ~p_scl;
            e_fall   = ~m_scl & p_scl;
            e_start  = p_sda & ~m_sda & p_scl & m_scl;
            e_stop   = ~p_sda & m_sda & p_scl & m_scl;
            e_rstart = e_start & m_busy;
            if (e_rise) e_bit = m_sda;
            nb = m_busy; ns = m_stuck;
            was_busy_only = m_busy && !m_stuck;
            if (!m_busy) begin
                if (e_start) nb = 1'b1;
            end else if (!m_stuck) begin
                if (e_stop) nb = 1'b0;
                else if (!e_start && m_low >= int'(TOUT)) ns = 1'b1;
            end else begin
                if (e_rise || e_start) ns = 1'b0;
                else if (e_stop) begin nb = 1'b0; ns = 1'b0; end
            end
            m_low   = (was_busy_only && nb && !ns && !m_scl) ? m_low + 1 : 0;
            m_busy  = nb;
            m_stuck = ns;
            n_scl = filt(h_scl, m_scl);
            n_sda = filt(h_sda, m_sda);
            p_scl = m_scl; p_sda = m_sda;
            m_scl = n_scl; m_sda = n_sda;
            h_scl = {h_scl[30:0], scl_in};
            h_sda = {h_sda[30:0], sda_in};
        end
    end

    logic [9:0] cmp_got, cmp_exp;
    always @(negedge clk) begin
        cmp_got = {scl_f, sda_f, scl_rise, scl_fall, sda_bit, start, rstart, stop, bus_busy, scl_stuck};
        cmp_exp = reset ? 10'b1100100000
                        : {m_scl, m_sda, e_rise, e_fall, e_bit, e_start, e_rstart, e_stop, m_busy, m_stuck};
        n_checks++;
        if (cmp_got !== cmp_exp) begin
            n_errors++;
            $display("FAIL cycle_compare t=%0t got=%b exp=%b (scl_f sda_f rise fall bit start rstart stop busy stuck)",
                     $time, cmp_got, cmp_exp);
        end
        if (start)    c_start++;
        if (rstart)   c_rstart++;
        if (stop)     c_stop++;
        if (scl_fall) c_fall++;
        if (scl_rise) bitq.push_back(sda_bit);
    end

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    task automatic drive(input logic scl_v, input logic sda_v);
        @(posedge clk);
        #3;
        scl_in = scl_v;
        sda_in = sda_v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Edges until the selected condition is seen (-1 if the bound expires)
    task automatic wait_until(input int sel, output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if ((sel == 0 && start) || (sel == 1 && stop) || (sel == 2 && scl_stuck) ||
                (sel == 3 && scl_rise) || (sel == 4 && !scl_f)) begin
                n = i;
                return;
            end
        end
    endtask

    int n, s_start, s_rstart, s_stop, s_fall;
    logic [7:0] byte_v;

    initial begin
        scl_in = 1'b1; sda_in = 1'b1; reset = 1'b1;
        wait_cyc(5);
        #3 reset = 1'b0;
        wait_cyc(20);
        #1;
        check("idle_bus_busy", bus_busy, 0);
        check("idle_scl_f", scl_f, 1);
        check("idle_sda_f", sda_f, 1);

        // START then STOP, latency from pin change to strobe
        drive(1'b1, 1'b0);
        wait_until(0, n);
        check("start_latency", n, EFL + 3);
        check("start_busy", bus_busy, 1);
        check("start_not_rstart", rstart, 0);
        wait_cyc(10);
        drive(1'b1, 1'b1);
        wait_until(1, n);
        check("stop_latency", n, EFL + 3);
        check("stop_busy", bus_busy, 0);
        wait_cyc(10);

        // SDA glitches with SCL high
        s_start = c_start;
        drive(1'b1, 1'b0); wait_cyc(1); drive(1'b1, 1'b1);
        wait_cyc(20);
        check("glitch2_starts", c_start - s_start, GLITCH2_STARTS);
        s_start = c_start;
        drive(1'b1, 1'b0); wait_cyc(2); drive(1'b1, 1'b1);
        wait_cyc(20);
        check("glitch3_starts", c_start - s_start, 1);

        // START, byte 0xA5, repeated START
        drive(1'b1, 1'b0);
        wait_cyc(15);
        bitq.delete();
        byte_v = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, sda_in); wait_cyc(4);
            drive(1'b0, byte_v[i]); wait_cyc(4);
            drive(1'b1, byte_v[i]); wait_cyc(9);
        end
        check("byte_rises", (bitq.size() >= 8) ? 1 : 0, 1);
        if (bitq.size() >= 8)
            for (int i = 0; i < 8; i++) check($sformatf("sda_bit_%0d", i), int'(bitq[i]), int'(byte_v[7-i]));
        drive(1'b0, sda_in); wait_cyc(4);
        drive(1'b0, 1'b1); wait_cyc(4);
        drive(1'b1, 1'b1); wait_cyc(9);
        s_rstart = c_rstart;
        drive(1'b1, 1'b0);
        wait_until(0, n);
        check("rstart_seen", (n > 0) ? int'(rstart) : 0, 1);
        check("rstart_busy", bus_busy, 1);
        wait_cyc(5);
        check("rstart_count", c_rstart - s_rstart, 1);

        // SCL held low until the watchdog trips, then released
        drive(1'b0, 1'b0);
        wait_until(4, n);
        wait_until(2, n);
        check("stuck_latency", n, int'(TOUT) + 1);
        check("stuck_busy", bus_busy, 1);
        wait_cyc(5);
        drive(1'b1, 1'b0);
        wait_until(3, n);
        check("unstuck_rise", (n > 0) ? 1 : 0, 1);
        check("unstuck_flag", scl_stuck, 0);
        check("unstuck_busy", bus_busy, 1);

        // SCL and SDA fall together while busy
        drive(1'b0, 1'b0); wait_cyc(5);
        drive(1'b0, 1'b1); wait_cyc(5);
        drive(1'b1, 1'b1); wait_cyc(10);
        s_start = c_start; s_stop = c_stop; s_fall = c_fall;
        drive(1'b0, 1'b0);
        wait_cyc(12);
        check("simul_fall", c_fall - s_fall, 1);
        check("simul_start", c_start - s_start, 0);
        check("simul_stop", c_stop - s_stop, 0);
        check("simul_busy", bus_busy, 1);

        // Reset mid-transfer, then a fresh START
        @(posedge clk);
        #3 reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
        #1;
        check("rst_busy", bus_busy, 0);
        check("rst_scl_f", scl_f, 1);
        wait_cyc(3);
        #3 reset = 1'b0;
        wait_cyc(10);
        drive(1'b1, 1'b0);
        wait_until(0, n);
        check("post_rst_start", n, EFL + 3);
        check("post_rst_rstart", rstart, 0);

        // Random pin activity, checked cycle by cycle against the model
        for (int it = 0; it < 300; it++) begin
            int act;
            act = int'($urandom_range(0, 19));
            if (act < 7)       drive(scl_in, ~sda_in);
            else if (act < 14) drive(~scl_in, sda_in);
            else if (act < 17) drive(~scl_in, ~sda_in);
            else if (act < 19) begin
                drive(1'b0, sda_in);
                wait_cyc(int'($urandom_range(48, 58)));
            end else begin
                @(posedge clk);
                #3 reset = 1'b1;
                wait_cyc(2);
                #3 reset = 1'b0;
            end
            wait_cyc(int'($urandom_range(0, 12)));
        end

        wait_cyc(20);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/i2c_bus_conditioner.md
# i2c_bus_conditioner

Front end of the I2C EEPROM slave. It synchronises the raw SCL/SDA pins into the system clock domain and optionally glitch-filters them. It then produces single-cycle SCL edge strobes and START / repeated-START / STOP strobes, and tracks bus ownership with a small state machine that includes an SCL-stuck-low watchdog. Its outputs feed the slave's bit-level protocol FSM, which receives `start`, `stop`, the SCL edge strobes and the sampled SDA bit instead of raw pin edges.

## Interface
- `FILTER_LEN`, default 3: consecutive samples of a new level required before the filtered line changes; legal range 1..15.
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles SCL may stay low while the bus is busy before `scl_stuck` is raised; at least 2.
- `clk` in, 1: system clock; everything is on its rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `scl_in` in, 1: raw SCL pin, asynchronous to `clk`.
- `sda_in` in, 1: raw SDA pin, asynchronous to `clk`.
- `scl_f` out, 1: synchronised, filtered SCL.
- `sda_f` out, 1: synchronised, filtered SDA.
- `scl_rise` out, 1: one-cycle strobe on a 0→1 transition of `scl_f`.
- `scl_fall` out, 1: one-cycle strobe on a 1→0 transition of `scl_f`.
- `sda_bit` out, 1: `sda_f` captured at each SCL rise; held between rises.
- `start` out, 1: one-cycle strobe for any START, including repeated START.
- `rstart` out, 1: one-cycle strobe, only for a START seen while the bus is already busy.
- `stop` out, 1: one-cycle strobe for a STOP condition.
- `bus_busy` out, 1: high from START until STOP.
- `scl_stuck` out, 1: watchdog flag.

## Operation
- **Reset values:** `scl_f`/`sda_f`/`sda_bit` = 1; all strobes, `bus_busy`, `scl_stuck` = 0; state FREE; filter and timeout counters = 0. The synchroniser flops reset to 1, so the bus reads as idle-high.
- **Synchroniser:** two flops per line, giving `scl_s` and `sda_s`.
- **Filter:** one counter per line.
  - The counter increments while the synchronised value differs from the filtered value, and clears whenever they match.
  - The filtered value takes the synchronised value on the edge where the mismatch has lasted `FILTER_LEN` consecutive cycles; the counter clears on that same edge.
  - A pulse shorter than `FILTER_LEN` cycles never reaches `scl_f`/`sda_f`.
- **Edge and condition detection:** compares the current filtered values with their registered previous values (`scl_p`, `sda_p`).
  - `scl_rise` = `scl_f & ~scl_p`.
  - `scl_fall` = `~scl_f & scl_p`.
  - START: `sda_p & ~sda_f & scl_p & scl_f`.
  - STOP: `~sda_p & sda_f & scl_p & scl_f`.
  - If SCL and SDA change in the same cycle, no START or STOP is produced; only the SCL edge strobe fires.
- **State machine:**
  - FREE → BUSY on START; asserts `start`.
  - BUSY → BUSY on START; asserts `start` and `rstart`.
  - BUSY → FREE on STOP; asserts `stop`.
  - BUSY → STUCK when the timeout counter reaches `TIMEOUT_CYCLES`.
  - STUCK → BUSY on `scl_rise`; clears `scl_stuck`.
  - STUCK → FREE on STOP; this can only happen after SCL rises, so in practice STUCK goes to BUSY first.
  - STOP in FREE still pulses `stop`; the state stays FREE.
  - START in STUCK is impossible, because SCL is low.
- **Outputs by state:** `bus_busy` = 1 in BUSY and STUCK. `scl_stuck` = 1 only in STUCK.
- **Timeout counter:**
  - Counts only in BUSY while `scl_f` = 0.
  - Clears on `scl_f` = 1, on any state change, and in FREE.
  - Saturates at `TIMEOUT_CYCLES`; width is `$clog2(TIMEOUT_CYCLES+1)`.
- **Reset during operation:** asserting `reset` mid-transfer returns to FREE immediately and drops all outputs to their reset values. The first START after reset is reported as a plain `start`, not `rstart`.

## Timing
- **Pin to filtered line:** a change on `scl_in`/`sda_in` appears on `scl_f`/`sda_f` `FILTER_LEN+2` cycles later, given the level is held.
- **Strobes:** `scl_rise`, `scl_fall`, `start`, `rstart`, `stop` are registered. Each asserts exactly one cycle, in the cycle after the filtered transition, i.e. `FILTER_LEN+3` cycles after the pin change.
- **`sda_bit`:** updates in the same cycle `scl_rise` is high.
- **`bus_busy`:** updates in the same cycle as the `start`/`stop` strobe.
- **Watchdog:** `scl_stuck` rises `TIMEOUT_CYCLES+1` cycles after `scl_f` falls.

## Configuration
- **`I2C_GLITCH_FILTER_EN` defined:** the filter counters are built exactly as described above.
- **`I2C_GLITCH_FILTER_EN` undefined:** `scl_f`/`sda_f` are the synchroniser outputs directly, and `FILTER_LEN` is ignored.
  - Pin-to-filtered latency is 2 cycles.
  - Pin-to-strobe latency is 3 cycles.
  - Every other behaviour is unchanged.

## Test plan
- **Reset state:** hold `reset` for 5 cycles with pins at 1/1, then release → `scl_f` = `sda_f` = 1, all strobes 0, `bus_busy` = 0, for 20 cycles.
- **START / STOP:** with `FILTER_LEN` = 3 and SCL = 1, drop SDA at cycle 10 → `start` high only at cycle 16 and `bus_busy` = 1. Later, raise SDA with SCL high → `stop` one cycle, 6 cycles after the change, and `bus_busy` = 0.
- **Glitch rejection (filter built in):** 2-cycle low pulse on `sda_in` with SCL high → no change on `sda_f`, no `start`. A 3-cycle pulse → `start` is produced.
- **Repeated START and data bit:** START, clock byte 0xA5 with 8 SCL pulses of 20 cycles, then SDA falls while SCL is high → eight `scl_rise` strobes with `sda_bit` sequence 1,0,1,0,0,1,0,1; then `start` = `rstart` = 1 for one cycle; `bus_busy` stays 1.
- **Stuck SCL:** with `TIMEOUT_CYCLES` = 50, hold SCL low after START → `scl_stuck` asserts 51 cycles after `scl_f` falls. Releasing SCL → `scl_rise`, and `scl_stuck` clears in the same cycle.
- **Simultaneous change and mid-transfer reset:** drop SCL and SDA in the same cycle while busy → `scl_fall` only, no `start`/`stop`. Assert `reset` while busy → FREE immediately; the next START gives `start` = 1 and `rstart` = 0.
